// File: rtl/drone_motor_arm_ctrl.sv
// rtl/drone_motor_arm_ctrl.sv - ESC arming, slew-limited throttle and watchdog failsafe controller
// Optional idle spin while armed: define MOTOR_IDLE_SPIN_EN.
module drone_motor_arm_ctrl #(
  parameter int NUM_MOTORS    = 4,
  parameter int REGBITDEPTH   = 8,
  parameter int TICK_DIV      = 100_000,
  parameter int ARM_TICKS     = 2000,
  parameter int TIMEOUT_TICKS = 100,
  parameter int SLEW_STEP     = 4,
  parameter int IDLE_LEVEL    = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              arm_req,
  input  logic                              disarm_req,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [NUM_MOTORS*REGBITDEPTH-1:0] cmd_data,
  output logic [NUM_MOTORS*REGBITDEPTH-1:0] motor_output,
  output logic                              armed,
  output logic [1:0]                        state,
  output logic [1:0]                        fault
);

  localparam int W  = REGBITDEPTH;
  localparam int VW = NUM_MOTORS * REGBITDEPTH;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ARM_TICKS + 1);
  localparam int WW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_TICKS - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_TICKS - 1);
  localparam logic [W-1:0]  STEP      = W'(SLEW_STEP);
  localparam logic [W-1:0]  IDLE_W    = W'(IDLE_LEVEL);

`ifdef MOTOR_IDLE_SPIN_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif

  localparam logic [1:0] S_DISARMED = 2'd0;
  localparam logic [1:0] S_ARMING   = 2'd1;
  localparam logic [1:0] S_ARMED    = 2'd2;
  localparam logic [1:0] S_FAILSAFE = 2'd3;

  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] arm_cnt, arm_nxt;
  logic [WW-1:0] wd_cnt, wd_nxt;
  logic [VW-1:0] tgt_q, tgt_nxt, out_nxt, slew_up, slew_down;
  logic [1:0]    state_nxt, fault_nxt;
  logic          tick, cmd_acc;

  // Moves cur toward tgt by at most STEP without overshoot or wrap.
  function automatic logic [W-1:0] slew_to(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W-1:0] res;
    if (tgt > cur) res = ((tgt - cur) > STEP) ? cur + STEP : tgt;
    else           res = ((cur - tgt) > STEP) ? cur - STEP : tgt;
    return res;
  endfunction

  function automatic logic [W-1:0] eff_target(input logic [W-1:0] tgt);
    return (IDLE_EN && (tgt < IDLE_W)) ? IDLE_W : tgt;
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign cmd_ready = (state != S_FAILSAFE);
  assign cmd_acc   = cmd_valid & cmd_ready;

  always_comb begin
    slew_up   = '0;
    slew_down = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      slew_up[i*W +: W]   = slew_to(motor_output[i*W +: W], eff_target(tgt_q[i*W +: W]));
      slew_down[i*W +: W] = slew_to(motor_output[i*W +: W], '0);
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt_q;
    out_nxt   = motor_output;
    arm_nxt   = arm_cnt;
    wd_nxt    = wd_cnt;
    fault_nxt = fault;
    if (cmd_acc) begin
      tgt_nxt = cmd_data;
      wd_nxt  = '0;
    end
    case (state)
      S_DISARMED: begin
        out_nxt = '0;
        wd_nxt  = '0;
        if (!disarm_req && arm_req) begin
          if (tgt_q == '0) begin
            state_nxt = S_ARMING;
            arm_nxt   = '0;
          end else begin
            fault_nxt[0] = 1'b1;
          end
        end
      end
      S_ARMING: begin
        out_nxt = '0;
        wd_nxt  = '0;
        if (disarm_req) begin
          state_nxt = S_DISARMED;
        end else if (cmd_acc && (cmd_data != '0)) begin
          arm_nxt = '0;
        end else if (tick) begin
          if (arm_cnt == ARM_LAST) begin
            state_nxt    = S_ARMED;
            fault_nxt[0] = 1'b0;
            arm_nxt      = '0;
          end else begin
            arm_nxt = arm_cnt + 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (disarm_req) begin
          state_nxt = S_DISARMED;
          out_nxt   = '0;
        end else if (tick) begin
          // Slew uses the registered targets, so a command landing on this tick waits for the next.
          out_nxt = slew_up;
          if (!cmd_acc) begin
            if (wd_cnt == WD_LAST) begin
              state_nxt    = S_FAILSAFE;
              fault_nxt[1] = 1'b1;
              tgt_nxt      = '0;
            end
            wd_nxt = wd_cnt + 1'b1;
          end
        end
      end
      default: begin
        tgt_nxt = '0;
        wd_nxt  = '0;
        if (disarm_req) begin
          state_nxt = S_DISARMED;
          out_nxt   = '0;
        end else if (motor_output == '0) begin
          state_nxt = S_DISARMED;
        end else if (tick) begin
          out_nxt = slew_down;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt     <= '0;
      arm_cnt      <= '0;
      wd_cnt       <= '0;
      tgt_q        <= '0;
      motor_output <= '0;
      state        <= S_DISARMED;
      armed        <= 1'b0;
      fault        <= 2'b00;
    end else begin
      tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
      arm_cnt      <= arm_nxt;
      wd_cnt       <= wd_nxt;
      tgt_q        <= tgt_nxt;
      motor_output <= out_nxt;
      state        <= state_nxt;
      armed        <= (state_nxt == S_ARMED);
      fault        <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_drone_motor_arm_ctrl.sv
// tb/tb_drone_motor_arm_ctrl.sv - scenario and randomized checks for drone_motor_arm_ctrl
module tb_drone_motor_arm_ctrl;

  localparam int NM = 4;
  localparam int W  = 8;
  localparam int TD = 10;
  localparam int AT = 5;
  localparam int TO = 8;
  localparam int SS = 4;
  localparam int IL = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            arm_req = 1'b0;
  logic            disarm_req = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [NM*W-1:0] cmd_data = '0;
  logic [NM*W-1:0] motor_output;
  logic            armed;
  logic [1:0]      state;
  logic [1:0]      fault;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n;
  int m_out[NM];
  int m_tgt[NM];
  bit dummy_tick;

  drone_motor_arm_ctrl #(
    .NUM_MOTORS(NM), .REGBITDEPTH(W), .TICK_DIV(TD), .ARM_TICKS(AT),
    .TIMEOUT_TICKS(TO), .SLEW_STEP(SS), .IDLE_LEVEL(IL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm_req(arm_req), .disarm_req(disarm_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .motor_output(motor_output), .armed(armed), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; every TD-th edge applies a control tick.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [NM*W-1:0] rep(input logic [W-1:0] b);
    return {NM{b}};
  endfunction

  function automatic int eff(input int t);
`ifdef MOTOR_IDLE_SPIN_EN
    return (t < IL) ? IL : t;
`else
    return t;
`endif
  endfunction

  function automatic int approach(input int cur, input int tgt);
    if (tgt > cur) return (cur + SS < tgt) ? cur + SS : tgt;
    return (cur - SS > tgt) ? cur - SS : tgt;
  endfunction

  function automatic logic [NM*W-1:0] model_vec();
    logic [NM*W-1:0] v;
    for (int i = 0; i < NM; i++) v[i*W +: W] = W'(m_out[i]);
    return v;
  endfunction

  task automatic model_tick();
    for (int i = 0; i < NM; i++) m_out[i] = approach(m_out[i], eff(m_tgt[i]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do step(); while (edge_n % TD != 0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; arm_req = 1'b0; disarm_req = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [NM*W-1:0] d, output bit was_tick);
    cmd_data  = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    was_tick  = (edge_n % TD == 0);
  endtask

  task automatic arm_seq();
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    wait_ticks(AT);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (motor_output !== '0) $display("FAIL reset_out: got %h want 0", motor_output); else n_pass++;
    n_checks++; if (armed !== 1'b0) $display("FAIL reset_armed: got %b want 0", armed); else n_pass++;
    n_checks++; if (fault !== 2'b00) $display("FAIL reset_fault: got %b want 00", fault); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_arm_ok();
    do_reset();
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    n_checks++; if (state !== 2'd1) $display("FAIL arm_enter: got %0d want 1", state); else n_pass++;
    wait_ticks(AT - 1);
    n_checks++; if (state !== 2'd1) $display("FAIL arm_early: got %0d want 1", state); else n_pass++;
    wait_ticks(1);
    n_checks++; if (state !== 2'd2) $display("FAIL arm_done: got %0d want 2", state); else n_pass++;
    n_checks++; if (armed !== 1'b1) $display("FAIL arm_armed: got %b want 1", armed); else n_pass++;
    n_checks++; if (motor_output !== '0) $display("FAIL arm_out: got %h want 0", motor_output); else n_pass++;
  endtask

  task automatic test_arm_reject();
    do_reset();
    send(32'h0000_0020, dummy_tick);
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    n_checks++; if (state !== 2'd0) $display("FAIL rej_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (fault !== 2'b01) $display("FAIL rej_fault: got %b want 01", fault); else n_pass++;
    send('0, dummy_tick);
    arm_seq();
    n_checks++; if (state !== 2'd2) $display("FAIL rej_rearm: got %0d want 2", state); else n_pass++;
    n_checks++; if (fault !== 2'b00) $display("FAIL rej_clear: got %b want 00", fault); else n_pass++;
  endtask

  task automatic test_slew();
    logic [W-1:0] exp_seq[6];
    exp_seq = '{8'h04, 8'h08, 8'h0A, 8'h0A, 8'h06, 8'h02};
    send(rep(8'h0A), dummy_tick);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) send(rep(8'h0A), dummy_tick);
      if (k == 4) send(rep(8'h02), dummy_tick);
      wait_ticks(1);
      n_checks++;
      if (motor_output !== rep(exp_seq[k]))
        $display("FAIL slew_%0d: got %h want %h", k, motor_output, rep(exp_seq[k]));
      else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    arm_seq();
    send(rep(8'h0C), dummy_tick);
    wait_ticks(3);
    n_checks++; if (motor_output !== rep(8'h0C)) $display("FAIL wd_level: got %h want 0c", motor_output); else n_pass++;
    wait_ticks(TO - 4);
    n_checks++; if (state !== 2'd2) $display("FAIL wd_early: got %0d want 2", state); else n_pass++;
    wait_ticks(1);
    n_checks++; if (state !== 2'd3) $display("FAIL wd_state: got %0d want 3", state); else n_pass++;
    n_checks++; if (fault !== 2'b10) $display("FAIL wd_fault: got %b want 10", fault); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL wd_ready: got %b want 0", cmd_ready); else n_pass++;
    n_checks++; if (armed !== 1'b0) $display("FAIL wd_armed: got %b want 0", armed); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      wait_ticks(1);
      n_checks++;
      if (motor_output !== rep(W'(8 - 4 * k)))
        $display("FAIL wd_ramp_%0d: got %h want %h", k, motor_output, rep(W'(8 - 4 * k)));
      else n_pass++;
    end
    n_checks++; if (state !== 2'd3) $display("FAIL wd_hold: got %0d want 3", state); else n_pass++;
    step();
    n_checks++; if (state !== 2'd0) $display("FAIL wd_disarm: got %0d want 0", state); else n_pass++;
    n_checks++; if (fault !== 2'b10) $display("FAIL wd_sticky: got %b want 10", fault); else n_pass++;
  endtask

  task automatic test_priority_reset();
    do_reset();
    arm_req = 1'b1; disarm_req = 1'b1;
    step();
    arm_req = 1'b0; disarm_req = 1'b0;
    step();
    n_checks++; if (state !== 2'd0) $display("FAIL prio_both: got %0d want 0", state); else n_pass++;
    arm_seq();
    send(rep(8'h28), dummy_tick);
    wait_ticks(5);
    send(rep(8'h28), dummy_tick);
    wait_ticks(5);
    n_checks++; if (motor_output !== rep(8'h28)) $display("FAIL prio_level: got %h want 28", motor_output); else n_pass++;
    disarm_req = 1'b1;
    step();
    disarm_req = 1'b0;
    n_checks++; if (motor_output !== '0) $display("FAIL prio_disarm_out: got %h want 0", motor_output); else n_pass++;
    n_checks++; if (state !== 2'd0) $display("FAIL prio_disarm_state: got %0d want 0", state); else n_pass++;
    do_reset();
    arm_seq();
    send(rep(8'h14), dummy_tick);
    wait_ticks(TO);
    n_checks++; if (state !== 2'd3) $display("FAIL prio_fs: got %0d want 3", state); else n_pass++;
    wait_ticks(1);
    n_checks++; if (motor_output !== rep(8'h10)) $display("FAIL prio_fs_ramp: got %h want 10", motor_output); else n_pass++;
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (motor_output !== '0) $display("FAIL async_out: got %h want 0", motor_output); else n_pass++;
    n_checks++; if (fault !== 2'b00) $display("FAIL async_fault: got %b want 00", fault); else n_pass++;
    n_checks++; if (state !== 2'd0) $display("FAIL async_state: got %0d want 0", state); else n_pass++;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_idle_spin();
    do_reset();
    arm_seq();
    n_checks++; if (state !== 2'd2) $display("FAIL idle_armed: got %0d want 2", state); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      wait_ticks(1);
      n_checks++;
      if (motor_output !== rep(W'((4 * k > IL) ? IL : 4 * k)))
        $display("FAIL idle_ramp_%0d: got %h want %h", k, motor_output, rep(W'((4 * k > IL) ? IL : 4 * k)));
      else n_pass++;
    end
  endtask

  task automatic test_random_slew();
    logic [NM*W-1:0] d;
    bit              tk;
    do_reset();
    arm_seq();
    for (int i = 0; i < NM; i++) begin m_out[i] = 0; m_tgt[i] = 0; end
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NM; i++) d[i*W +: W] = W'($urandom_range(0, 255));
      send(d, tk);
      if (tk) model_tick();
      for (int i = 0; i < NM; i++) m_tgt[i] = int'(d[i*W +: W]);
      repeat ($urandom_range(1, 3)) begin
        wait_ticks(1);
        model_tick();
      end
      n_checks++;
      if (motor_output !== model_vec())
        $display("FAIL rand_%0d: got %h want %h", it, motor_output, model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
`ifdef MOTOR_IDLE_SPIN_EN
    test_idle_spin();
`else
    test_arm_ok();
    test_slew();
    test_arm_reject();
    test_watchdog();
    test_priority_reset();
`endif
    test_random_slew();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
